// File: rtl/trace_capture_buffer_if.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer_if
// Bundles the control, sample and read-out signals of trace_capture_buffer.
//   master : drives arm/clear/sample_en/trigger/data/read_ready, observes status
//   slave  : the capture buffer itself
// Parameters CH, W, DEPTH must match those of the attached buffer.
// Optional macro TRACE_TIMESTAMP_EN adds read_time[15:0] (slave output).
// -----------------------------------------------------------------------------
interface trace_capture_buffer_if #(
    parameter int CH    = 4,
    parameter int W     = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 arm;
    logic                 clear;
    logic                 sample_en;
    logic                 trigger;
    logic [CH*W-1:0]      data;
    logic                 read_ready;
    logic                 read_valid;
    logic [CH*W-1:0]      read_data;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic [1:0]           state;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]          read_time;
`endif

    modport master (
        output arm, clear, sample_en, trigger, data, read_ready,
        input  read_valid, read_data, count, full, empty, overflow, state
`ifdef TRACE_TIMESTAMP_EN
        , input read_time
`endif
    );

    modport slave (
        input  arm, clear, sample_en, trigger, data, read_ready,
        output read_valid, read_data, count, full, empty, overflow, state
`ifdef TRACE_TIMESTAMP_EN
        , output read_time
`endif
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer
// Logic-analyser style capture buffer: after arm it samples continuously into a
// circular buffer (oldest entries overwritten when full), on trigger it keeps
// POST further samples, then drains the stored window oldest-first through a
// first-word-fall-through valid/ready read port.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   Reset  : synchronous active-high reset
//   bus    : trace_capture_buffer_if.slave
//            arm, clear, sample_en, trigger, data[CH*W], read_ready (in)
//            read_valid, read_data[CH*W], count, full, empty, overflow,
//            state (0 IDLE, 1 PRE, 2 POST, 3 DONE) (out)
//
// Optional macro TRACE_TIMESTAMP_EN: adds a free-running 16-bit cycle counter;
// every stored entry keeps the counter value of its store cycle, shown on
// bus.read_time alongside bus.read_data.
// -----------------------------------------------------------------------------
module trace_capture_buffer #(
    parameter int CH    = 4,
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int POST  = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    trace_capture_buffer_if.slave bus
);
    localparam int DW = CH * W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [DW-1:0]  mem [DEPTH];

    logic [1:0]     state_reg,     state_next;
    logic [AW-1:0]  wr_ptr_reg,    wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg,    rd_ptr_next;
    logic [CW-1:0]  count_reg,     count_next;
    logic [CW-1:0]  remaining_reg, remaining_next;
    logic           overflow_reg,  overflow_next;

    logic           full;
    logic           store;
    logic           read_valid;
    logic           pop;

    assign full       = (count_reg == DEPTH_C);
    // clear wins over any same-cycle sample or pop
    assign store      = bus.sample_en && !bus.clear &&
                        ((state_reg == S_PRE) || (state_reg == S_POST));
    assign read_valid = (state_reg == S_DONE) && (count_reg != '0);
    assign pop        = read_valid && bus.read_ready && !bus.clear;

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        remaining_next = remaining_reg;
        overflow_next  = overflow_reg;

        if (bus.clear) begin
            state_next     = S_IDLE;
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            remaining_next = '0;
            overflow_next  = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.arm) begin
                        state_next    = S_PRE;
                        wr_ptr_next   = '0;
                        rd_ptr_next   = '0;
                        count_next    = '0;
                        overflow_next = 1'b0;
                    end
                end
                S_PRE, S_POST: begin
                    if (store) begin
                        // DEPTH is a power of two, so pointer wrap is free
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (full) begin
                            // keep the newest DEPTH samples: drop the oldest
                            rd_ptr_next   = rd_ptr_reg + 1'b1;
                            overflow_next = 1'b1;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                    if (state_reg == S_PRE) begin
                        // a sample taken in the trigger cycle counts as pre-trigger
                        if (bus.trigger) begin
                            if (POST_C == '0) begin
                                state_next = S_DONE;
                            end else begin
                                state_next     = S_POST;
                                remaining_next = POST_C;
                            end
                        end
                    end else if (store) begin
                        remaining_next = remaining_reg - 1'b1;
                        if (remaining_reg == ONE_C) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (count_reg == '0) begin
                        state_next = S_IDLE;
                    end else if (pop) begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                        count_next  = count_reg - 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            remaining_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            remaining_reg <= remaining_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Storage is never reset; contents are only meaningful below count_reg.
    // The read is asynchronous because the head entry must be visible in the
    // same cycle the read pointer moves (first-word fall-through).
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_reg] <= bus.data;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_reg;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (Reset) begin
            ts_reg <= 16'd0;
        end else begin
            ts_reg <= ts_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            ts_mem[wr_ptr_reg] <= ts_reg;
        end
    end

    assign bus.read_time = ts_mem[rd_ptr_reg];
`endif

    assign bus.read_valid = read_valid;
    assign bus.read_data  = mem[rd_ptr_reg];
    assign bus.count      = count_reg;
    assign bus.full       = full;
    assign bus.empty      = (count_reg == '0);
    assign bus.overflow   = overflow_reg;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// Bench for trace_capture_buffer (CH=4, W=16, DEPTH=8, POST=4) plus a second
// instance with POST=0. A queue-based reference model tracks the main instance
// every cycle; vector tables and short directed sequences cover the corners.
// -----------------------------------------------------------------------------
module tb_trace_capture_buffer;
    localparam int CH    = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int TPOST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_capture_buffer_if #(.CH(CH), .W(W), .DEPTH(DEPTH)) bus ();
    trace_capture_buffer_if #(.CH(CH), .W(W), .DEPTH(DEPTH)) bus0 ();

    trace_capture_buffer #(.CH(CH), .W(W), .DEPTH(DEPTH), .POST(TPOST)) u_dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    trace_capture_buffer #(.CH(CH), .W(W), .DEPTH(DEPTH), .POST(0)) u_dut0 (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus0)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (behavioural, queue based) -------------
    int          m_st;
    int          m_rem;
    bit          m_ovf;
    logic [15:0] m_ts;
    logic [79:0] m_q [$];   // {timestamp, data}

    function automatic void m_push(logic [63:0] d);
        if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
        end
        m_q.push_back({m_ts, d});
    endfunction

    function automatic void model_step(bit rs, bit a, bit c, bit s, bit t, bit r, logic [63:0] d);
        if (rs) begin
            m_q.delete(); m_st = 0; m_rem = 0; m_ovf = 1'b0; m_ts = 16'd0;
            return;
        end
        if (c) begin
            m_q.delete(); m_st = 0; m_rem = 0; m_ovf = 1'b0;
        end else begin
            case (m_st)
                0: if (a) begin m_q.delete(); m_ovf = 1'b0; m_st = 1; end
                1: begin
                    if (s) m_push(d);
                    if (t) begin m_st = 2; m_rem = TPOST; end
                end
                2: if (s) begin
                    m_push(d);
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_st = 3;
                end
                default: begin
                    if (m_q.size() == 0) m_st = 0;
                    else if (r) void'(m_q.pop_front());
                end
            endcase
        end
        m_ts = m_ts + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit v;
        v = (m_st == 3) && (m_q.size() != 0);
        chk("model state",    80'(bus.state),      80'(m_st));
        chk("model count",    80'(bus.count),      80'(m_q.size()));
        chk("model empty",    80'(bus.empty),      80'(m_q.size() == 0));
        chk("model full",     80'(bus.full),       80'(m_q.size() == DEPTH));
        chk("model overflow", 80'(bus.overflow),   80'(m_ovf));
        chk("model valid",    80'(bus.read_valid), 80'(v));
        if (v) begin
            chk("model rdata", 80'(bus.read_data), 80'(m_q[0][63:0]));
`ifdef TRACE_TIMESTAMP_EN
            chk("model rtime", 80'(bus.read_time), 80'(m_q[0][79:64]));
`endif
        end
    endtask

    // apply one cycle of inputs to the main instance, advance model, compare
    task automatic cycle(input bit rs, input bit a, input bit c, input bit s,
                         input bit t, input bit r, input logic [63:0] d);
        rst            = rs;
        bus.arm        = a;
        bus.clear      = c;
        bus.sample_en  = s;
        bus.trigger    = t;
        bus.read_ready = r;
        bus.data       = d;
        model_step(rs, a, c, s, t, r, d);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(); cycle(0, 0, 0, 0, 0, 0, 64'd0); endtask
    task automatic smp(input logic [63:0] d); cycle(0, 0, 0, 1, 0, 0, d); endtask
    task automatic do_reset(); cycle(1, 0, 0, 0, 0, 0, 64'd0); endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        bit          arm, clr, se, trig, rr;
        logic [15:0] d;
        logic [1:0]  st;
        logic [3:0]  cnt;
        bit          vld;
        logic [15:0] rd;
        bit          ovf;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input bit a, input bit c, input bit s, input bit t, input bit r,
                       input logic [15:0] d, input logic [1:0] st, input logic [3:0] cnt,
                       input bit v, input logic [15:0] rd, input bit ov);
        vec_t e;
        e.arm = a; e.clr = c; e.se = s; e.trig = t; e.rr = r; e.d = d;
        e.st = st; e.cnt = cnt; e.vld = v; e.rd = rd; e.ovf = ov;
        tbl.push_back(e);
    endtask

    logic [63:0] held;
    logic [15:0] t0;

    initial begin
        bus.arm = 0; bus.clear = 0; bus.sample_en = 0; bus.trigger = 0;
        bus.read_ready = 0; bus.data = '0;
        bus0.arm = 0; bus0.clear = 0; bus0.sample_en = 0; bus0.trigger = 0;
        bus0.read_ready = 0; bus0.data = '0;

        // basic capture: 3 pre samples, trigger alone, 4 post, drain 1..7
        add(1,0,0,0,0, 0, 1, 0, 0, 0, 0);
        add(0,0,1,0,0, 1, 1, 1, 0, 0, 0);
        add(0,0,1,0,0, 2, 1, 2, 0, 0, 0);
        add(0,0,1,0,0, 3, 1, 3, 0, 0, 0);
        add(0,0,0,1,0, 0, 2, 3, 0, 0, 0);
        add(0,0,1,0,0, 4, 2, 4, 0, 0, 0);
        add(0,0,1,0,0, 5, 2, 5, 0, 0, 0);
        add(0,0,1,0,0, 6, 2, 6, 0, 0, 0);
        add(0,0,1,0,0, 7, 3, 7, 1, 1, 0);
        for (int k = 1; k <= 6; k++) add(0,0,0,0,1, 0, 3, 4'(7 - k), 1, 16'(k + 1), 0);
        add(0,0,0,0,1, 0, 3, 0, 0, 0, 0);
        add(0,0,0,0,0, 0, 0, 0, 0, 0, 0);
        // clear during POST, then trigger and sample must be ignored
        add(1,0,0,0,0, 0, 1, 0, 0, 0, 0);
        add(0,0,1,0,0, 1, 1, 1, 0, 0, 0);
        add(0,0,1,1,0, 2, 2, 2, 0, 0, 0);
        add(0,0,1,0,0, 3, 2, 3, 0, 0, 0);
        add(0,0,1,0,0, 4, 2, 4, 0, 0, 0);
        add(0,1,1,0,0, 9, 0, 0, 0, 0, 0);
        add(0,0,0,1,0, 0, 0, 0, 0, 0, 0);
        add(0,0,1,0,0, 5, 0, 0, 0, 0, 0);

        do_reset();
        chk("reset state", 80'(bus.state), 80'd0);
        chk("reset empty", 80'(bus.empty), 80'd1);
        chk("reset full",  80'(bus.full),  80'd0);
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(0, tbl[i].arm, tbl[i].clr, tbl[i].se, tbl[i].trig, tbl[i].rr, 64'(tbl[i].d));
            chk($sformatf("vec%0d state", i), 80'(bus.state), 80'(tbl[i].st));
            chk($sformatf("vec%0d count", i), 80'(bus.count), 80'(tbl[i].cnt));
            chk($sformatf("vec%0d valid", i), 80'(bus.read_valid), 80'(tbl[i].vld));
            chk($sformatf("vec%0d ovf", i),   80'(bus.overflow), 80'(tbl[i].ovf));
            if (tbl[i].vld) chk($sformatf("vec%0d rdata", i), 80'(bus.read_data), 80'(tbl[i].rd));
        end

        // wraparound: 10 samples into 8 entries, then 4 post, drain 7..14
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 64'd0);
        for (int i = 1; i <= 10; i++) smp(64'(i));
        chk("wrap full", 80'(bus.full), 80'd1);
        chk("wrap ovf",  80'(bus.overflow), 80'd1);
        cycle(0, 0, 0, 0, 1, 0, 64'd0);
        for (int i = 11; i <= 14; i++) smp(64'(i));
        chk("wrap done", 80'(bus.state), 80'd3);
        for (int i = 7; i <= 14; i++) begin
            chk("wrap rdata", 80'(bus.read_data), 80'(i));
            cycle(0, 0, 0, 0, 0, 1, 64'd0);
        end
        idle();
        chk("wrap idle", 80'(bus.state), 80'd0);

        // back-pressure with 3 entries, then 3 consecutive pops
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 64'd0);
        cycle(0, 0, 0, 0, 1, 0, 64'd0);
        for (int i = 10; i <= 13; i++) smp(64'(i));
        cycle(0, 0, 0, 0, 0, 1, 64'd0);
        chk("bp count3", 80'(bus.count), 80'd3);
        held = bus.read_data;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0, 0, 64'hdead);
            chk("bp valid", 80'(bus.read_valid), 80'd1);
            chk("bp rdata", 80'(bus.read_data), 80'd11);
            chk("bp stable", 80'(bus.read_data), 80'(held));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 64'd0);
        chk("bp empty", 80'(bus.empty), 80'd1);
        chk("bp still done", 80'(bus.state), 80'd3);
        idle();
        chk("bp idle", 80'(bus.state), 80'd0);

        // reset while draining with 5 entries
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 64'd0);
        smp(64'd1);
        cycle(0, 0, 0, 0, 1, 0, 64'd0);
        for (int i = 2; i <= 5; i++) smp(64'(i));
        chk("rd count5", 80'(bus.count), 80'd5);
        do_reset();
        chk("rd state", 80'(bus.state), 80'd0);
        chk("rd count", 80'(bus.count), 80'd0);
        chk("rd valid", 80'(bus.read_valid), 80'd0);
        rst = 0;

        // POST=0 instance: trigger in PRE goes straight to DONE
        bus0.arm = 1; idle(); bus0.arm = 0;
        chk("p0 pre", 80'(bus0.state), 80'd1);
        bus0.sample_en = 1; bus0.data = 64'd9; idle();
        bus0.trigger = 1; bus0.data = 64'd10; idle();
        bus0.sample_en = 0; bus0.trigger = 0;
        chk("p0 done",  80'(bus0.state), 80'd3);
        chk("p0 count", 80'(bus0.count), 80'd2);
        chk("p0 rdata", 80'(bus0.read_data), 80'd9);
        bus0.read_ready = 1; idle();
        chk("p0 rdata2", 80'(bus0.read_data), 80'd10);
        idle(); idle();
        bus0.read_ready = 0;
        chk("p0 idle", 80'(bus0.state), 80'd0);

`ifdef TRACE_TIMESTAMP_EN
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 64'd0);
        idle(); idle();
        smp(64'd1);
        idle();
        smp(64'd2);
        cycle(0, 0, 0, 0, 1, 0, 64'd0);
        for (int i = 3; i <= 6; i++) smp(64'(i));
        t0 = bus.read_time;
        cycle(0, 0, 0, 0, 0, 1, 64'd0);
        chk("ts delta", 80'(bus.read_time - t0), 80'd2);
`endif

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(299) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(49) == 0), ($urandom_range(9) < 6),
                  ($urandom_range(9) == 0), ($urandom_range(1) == 1),
                  {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
